// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and types for the CNN front end.
//
// Contents:
//   DEF_IMG_SIZE   default image side length (28)
//   IMG_PIXELS     pixels per frame (DEF_IMG_SIZE^2 = 784)
//   PIX_W          default pixel width in bits (8)
//   IDX_W          width of a raster index into one frame
//   pixel_t        one pixel
//   loader_state_t frame loader states; PENDING is reachable only when the
//                  loader is built with IMAGE_LOADER_DOUBLE_BUFFER_EN
package cnn_pkg;

  localparam int DEF_IMG_SIZE = 28;
  localparam int IMG_PIXELS   = DEF_IMG_SIZE * DEF_IMG_SIZE;
  localparam int PIX_W        = 8;
  localparam int IDX_W        = $clog2(IMG_PIXELS);

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    PENDING = 2'd3
  } loader_state_t;

endpackage

// File: rtl/frame_bank.sv
// frame_bank: one frame of pixel storage, written one pixel per cycle at a
// raster index and read in parallel as an unpacked array.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-low reset; clears every entry to 0
//   wr_en    write strobe
//   wr_idx   raster index to write
//   wr_data  pixel value to write
//   data     all stored pixels, raster order, continuously driven
module frame_bank #(
  parameter int PIXELS     = 784,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] data [0:PIXELS-1]
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PIXELS; i++) begin
        data[i] <= '0;
      end
    end else if (wr_en) begin
      data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/image_frame_loader.sv
// image_frame_loader: collects a serial pixel stream into a 28x28 frame and
// hands the complete frame to the CNN as a parallel array.
//
// Handshake: a pixel transfers on a rising edge where pix_valid and
// pix_ready are both high. pix_ready depends only on state and rst, never on
// pix_valid; the upstream side must hold pix_data/pix_last steady while
// pix_valid is high and pix_ready is low.
//
// Framing: a frame is exactly IMG_SIZE*IMG_SIZE pixels with pix_last on the
// final one. pix_last early, or a full frame without pix_last, discards the
// frame and pulses frame_err for one cycle.
//
// Ports:
//   clk, rst    clock; synchronous active-low reset
//   pix_valid   upstream pixel valid
//   pix_ready   loader accepts a pixel this cycle
//   pix_data    pixel value
//   pix_last    final pixel of a frame
//   cnn_done    CNN finished with the presented frame (releases it)
//   valid_out   one-cycle pulse: image_out holds a complete frame
//   image_out   frame array, raster order
//   busy        high whenever the loader is not in FILL
//   frame_err   one-cycle pulse after a framing error
//   frame_cnt   number of launched frames, wrapping
//
// Build option IMAGE_LOADER_DOUBLE_BUFFER_EN: two ping-pong banks. While the
// CNN holds the active bank (WAIT), the next frame fills the other bank; a
// frame completed early parks in PENDING until cnn_done swaps the banks.
// Without the macro there is a single bank and PENDING is never entered.
module image_frame_loader
  import cnn_pkg::*;
#(
  parameter int IMG_SIZE   = DEF_IMG_SIZE,
  parameter int DATA_WIDTH = PIX_W,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_last,
  input  logic                  cnn_done,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] image_out [0:IMG_SIZE*IMG_SIZE-1],
  output logic                  busy,
  output logic                  frame_err,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam int PIXELS = IMG_SIZE * IMG_SIZE;
  localparam int IW     = $clog2(PIXELS);
  localparam logic [IW-1:0] LAST_IDX = IW'(PIXELS - 1);

  loader_state_t state, state_next;
  logic [IW-1:0] wr_idx, wr_idx_next;
  logic          err_next;
  logic          fill_done;
  logic          xfer;

`ifdef IMAGE_LOADER_DOUBLE_BUFFER_EN
  logic swap;
  logic sel;       // bank shown on image_out
  logic wr_bank;   // bank receiving pixels
`endif

  // Ready is a function of state only; in the ping-pong build the loader
  // also accepts while the CNN works on the active bank.
`ifdef IMAGE_LOADER_DOUBLE_BUFFER_EN
  assign pix_ready = rst && ((state == FILL) || (state == WAIT));
`else
  assign pix_ready = rst && (state == FILL);
`endif

  assign xfer      = pix_valid && pix_ready;
  assign valid_out = (state == LAUNCH);
  assign busy      = (state != FILL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FILL;
      wr_idx    <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      wr_idx    <= wr_idx_next;
      frame_err <= err_next;
      if (state == LAUNCH) begin
        frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_next  = state;
    wr_idx_next = wr_idx;
    err_next    = 1'b0;
    fill_done   = 1'b0;
`ifdef IMAGE_LOADER_DOUBLE_BUFFER_EN
    swap        = 1'b0;
`endif

    // Framing check, independent of which state is accepting. Any framing
    // outcome (good or bad) restarts the write index for the next frame.
    if (xfer) begin
      if (wr_idx == LAST_IDX) begin
        wr_idx_next = '0;
        if (pix_last) begin
          fill_done = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end else if (pix_last) begin
        wr_idx_next = '0;
        err_next    = 1'b1;
      end else begin
        wr_idx_next = wr_idx + IW'(1);
      end
    end

    case (state)
      FILL: begin
        if (fill_done) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        state_next = WAIT;
      end
      WAIT: begin
`ifdef IMAGE_LOADER_DOUBLE_BUFFER_EN
        // A release with a partial fill hands the filling bank over to FILL
        // so the stream continues into the same storage without restarting.
        if (fill_done) begin
          if (cnn_done) begin
            state_next = LAUNCH;
            swap       = 1'b1;
          end else begin
            state_next = PENDING;
          end
        end else if (cnn_done) begin
          state_next = FILL;
          swap       = 1'b1;
        end
`else
        if (cnn_done) begin
          state_next = FILL;
        end
`endif
      end
      PENDING: begin
`ifdef IMAGE_LOADER_DOUBLE_BUFFER_EN
        if (cnn_done) begin
          state_next = LAUNCH;
          swap       = 1'b1;
        end
`else
        state_next = FILL;
`endif
      end
      default: state_next = FILL;
    endcase
  end

`ifdef IMAGE_LOADER_DOUBLE_BUFFER_EN
  logic [DATA_WIDTH-1:0] bank0 [0:PIXELS-1];
  logic [DATA_WIDTH-1:0] bank1 [0:PIXELS-1];

  // FILL writes the shown bank (nothing is presented yet); WAIT writes the
  // hidden one so the presented frame is never disturbed.
  assign wr_bank = (state == FILL) ? sel : ~sel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel <= 1'b0;
    end else if (swap) begin
      sel <= ~sel;
    end
  end

  frame_bank #(
    .PIXELS(PIXELS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IW)
  ) u_bank0 (
    .clk(clk), .rst(rst), .wr_en(xfer && !wr_bank),
    .wr_idx(wr_idx), .wr_data(pix_data), .data(bank0)
  );

  frame_bank #(
    .PIXELS(PIXELS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IW)
  ) u_bank1 (
    .clk(clk), .rst(rst), .wr_en(xfer && wr_bank),
    .wr_idx(wr_idx), .wr_data(pix_data), .data(bank1)
  );

  for (genvar g = 0; g < PIXELS; g++) begin : g_mux
    assign image_out[g] = sel ? bank1[g] : bank0[g];
  end
`else
  // Single bank: pixels are only accepted in FILL, so the frame stays put
  // from LAUNCH until the cycle after cnn_done.
  frame_bank #(
    .PIXELS(PIXELS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IW)
  ) u_bank (
    .clk(clk), .rst(rst), .wr_en(xfer),
    .wr_idx(wr_idx), .wr_data(pix_data), .data(image_out)
  );
`endif

endmodule

// File: tb/tb_image_frame_loader.sv
// Bench for image_frame_loader: directed scenarios plus randomized pixel
// gaps and data, with a cycle-level reference model that rebuilds frames
// from observed transfers and predicts every output.
module tb_image_frame_loader;

  localparam int PIX = 784;
`ifdef IMAGE_LOADER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        pix_last;
  logic        cnn_done;
  logic        valid_out;
  logic [7:0]  image_out [0:PIX-1];
  logic        busy;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  image_frame_loader dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last), .cnn_done(cnn_done),
    .valid_out(valid_out), .image_out(image_out), .busy(busy),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Abstract view: pixels accumulate in cur_q; a complete frame goes to
  // exp_q and is copied into m_shown when it is presented.
  typedef enum int {M_ACC, M_LAUNCH, M_HELD, M_PEND} mphase_t;

  bit         mon_en = 1'b0;
  mphase_t    m_phase = M_ACC;
  int         m_cnt = 0;
  bit         m_err = 1'b0;
  logic [7:0] cur_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] m_shown [0:PIX-1];

  function automatic bit model_ready(input mphase_t ph);
    return (ph == M_ACC) || (DB && ph == M_HELD);
  endfunction

  always @(negedge clk) begin : monitor
    int      nmis;
    bit      mx, complete, go;
    mphase_t nph;
    if (mon_en) begin
      check("valid_out", valid_out, 32'(m_phase == M_LAUNCH));
      check("frame_err", frame_err, 32'(m_err));
      check("busy", busy, 32'(m_phase != M_ACC));
      check("pix_ready", pix_ready, 32'(rst && model_ready(m_phase)));
      check("frame_cnt", frame_cnt, 32'(m_cnt % 65536));
      if (m_phase != M_ACC) begin
        nmis = 0;
        for (int i = 0; i < PIX; i++) if (image_out[i] !== m_shown[i]) nmis++;
        check("image_hold", nmis, 0);
      end

      if (!rst) begin
        m_phase = M_ACC; m_cnt = 0; m_err = 1'b0;
        cur_q.delete(); exp_q.delete();
        for (int i = 0; i < PIX; i++) m_shown[i] = 8'h00;
      end else begin
        mx = pix_valid && model_ready(m_phase);
        complete = 1'b0; go = 1'b0; m_err = 1'b0; nph = m_phase;
        if (mx) begin
          cur_q.push_back(pix_data);
          if (pix_last || cur_q.size() == PIX) begin
            if (pix_last && cur_q.size() == PIX) begin
              foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
              complete = 1'b1;
            end else begin
              m_err = 1'b1;
            end
            cur_q.delete();
          end
        end
        case (m_phase)
          M_ACC:    if (complete) go = 1'b1;
          M_LAUNCH: begin m_cnt++; nph = M_HELD; end
          M_HELD: begin
            if (complete) begin
              if (cnn_done) go = 1'b1; else nph = M_PEND;
            end else if (cnn_done) begin
              nph = M_ACC;
            end
          end
          M_PEND:   if (cnn_done) go = 1'b1;
          default:  nph = M_ACC;
        endcase
        if (go) begin
          for (int i = 0; i < PIX; i++) m_shown[i] = exp_q.pop_front();
          nph = M_LAUNCH;
        end
        m_phase = nph;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pixel(input logic [7:0] d, input logic last, input int idle_pct);
    int budget;
    while ($urandom_range(99, 0) < idle_pct) begin
      pix_valid = 1'b0;
      tick(1);
    end
    pix_valid = 1'b1; pix_data = d; pix_last = last;
    budget = 0;
    while (!pix_ready && budget < 3000) begin tick(1); budget++; end
    if (budget >= 3000) check("accept_timeout", pix_ready, 1);
    tick(1);
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  // last_at < 0: no pix_last in the burst
  task automatic send_frame(input int n, input int last_at, input int idle_pct,
                            input bit rnd, input int base);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom_range(255, 0)) : 8'(base + i);
      send_pixel(d, (i == last_at), idle_pct);
    end
  endtask

  task automatic pulse_done();
    cnn_done = 1'b1;
    tick(1);
    cnn_done = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    int nmis;
    pix_valid = 1'b0; pix_last = 1'b0; cnn_done = 1'b0;
    rst = 1'b0;
    #1;
    check({tag, "_ready_in_rst"}, pix_ready, 0);
    tick(2);
    nmis = 0;
    for (int i = 0; i < PIX; i++) if (image_out[i] !== 8'h00) nmis++;
    check({tag, "_image_zero"}, nmis, 0);
    check({tag, "_cnt_zero"}, frame_cnt, 0);
    rst = 1'b1;
    tick(1);
  endtask

  // ---------------- test sequence ----------------
  initial begin : stim
    int nmis;
    rst = 1'b0; pix_valid = 1'b0; pix_data = 8'h00; pix_last = 1'b0; cnn_done = 1'b0;
    tick(2);
    mon_en = 1'b1;
    do_reset("init");

    // Ramp frame: launch one cycle after the last accept.
    send_frame(PIX, PIX - 1, 0, 1'b0, 0);
    check("t1_valid_latency", valid_out, 1);
    nmis = 0;
    for (int i = 0; i < PIX; i++) if (image_out[i] !== 8'(i % 256)) nmis++;
    check("t1_image_ramp", nmis, 0);
    check("t1_image_last", image_out[PIX-1], 32'(783 % 256));
    tick(1);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_busy", busy, 1);

`ifndef IMAGE_LOADER_DOUBLE_BUFFER_EN
    // Held frame: upstream pushes but nothing is accepted until release.
    pix_valid = 1'b1; pix_data = 8'hA5;
    for (int c = 0; c < 50; c++) begin
      check("t2_ready_wait", pix_ready, 0);
      tick(1);
    end
    pulse_done();
    check("t2_ready_after_done", pix_ready, 1);
    check("t2_busy_after_done", busy, 0);
    pix_valid = 1'b0;
    tick(1);
`else
    pulse_done();
    tick(1);
`endif

    // Early pix_last on pixel 100.
    do_reset("t3");
    send_frame(101, 100, 0, 1'b1, 0);
    check("t3_err_pulse", frame_err, 1);
    check("t3_no_valid", valid_out, 0);
    send_frame(PIX, PIX - 1, 10, 1'b1, 0);
    check("t3_clean_valid", valid_out, 1);
    tick(1);
    check("t3_clean_cnt", frame_cnt, 1);
    pulse_done();

    // Full frame without pix_last, then a clean frame starting at index 0.
    do_reset("t4");
    send_frame(PIX, -1, 0, 1'b0, 7);
    check("t4_err_pulse", frame_err, 1);
    check("t4_no_valid", valid_out, 0);
    send_frame(PIX, PIX - 1, 0, 1'b0, 100);
    check("t4_clean_valid", valid_out, 1);
    check("t4_first_pix", image_out[0], 100);
    pulse_done();

    // Reset in the middle of a frame.
    do_reset("t5a");
    send_frame(400, -1, 0, 1'b1, 0);
    do_reset("t5");
    check("t5_busy", busy, 0);
    send_frame(PIX, PIX - 1, 0, 1'b1, 0);
    check("t5_fresh_valid", valid_out, 1);
    tick(1);
    check("t5_fresh_cnt", frame_cnt, 1);
    pulse_done();

    // Random gaps and data over three frames.
    do_reset("t6");
    for (int f = 0; f < 3; f++) begin
      send_frame(PIX, PIX - 1, 30, 1'b1, 0);
      tick($urandom_range(20, 1));
      pulse_done();
    end
    tick(2);
    check("t6_frame_cnt", frame_cnt, 3);

`ifdef IMAGE_LOADER_DOUBLE_BUFFER_EN
    // Second frame fills the hidden bank and launches right after release.
    do_reset("t7");
    send_frame(PIX, PIX - 1, 0, 1'b1, 0);
    tick(1);
    send_frame(PIX, PIX - 1, 20, 1'b1, 0);
    tick(5);
    check("t7_pending_ready", pix_ready, 0);
    pulse_done();
    check("t7_launch_after_done", valid_out, 1);
    tick(1);
    check("t7_frame_cnt", frame_cnt, 2);
    pulse_done();
    tick(2);
`endif

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_frame_loader.md
Name: image_frame_loader

Overview:
- Upstream feeder for the CNN top. Accepts a serial 8-bit pixel stream through a valid/ready handshake.
- Assembles the stream in raster order into a 28x28 frame buffer.
- Presents the frame as a parallel unpacked array with a one-cycle valid_out pulse.
- Holds the frame stable until the CNN reports completion through its valid_out, wired here as cnn_done.

Parameters:
- IMG_SIZE, 28, image side length; frame holds IMG_SIZE*IMG_SIZE pixels (784).
- DATA_WIDTH, 8, pixel width in bits.
- CNT_WIDTH, 16, width of the launched-frame counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-low.
- pix_valid  input  1  upstream pixel valid.
- pix_ready  output  1  loader can accept a pixel.
- pix_data  input  DATA_WIDTH  pixel value.
- pix_last  input  1  marks the final pixel of a frame.
- cnn_done  input  1  CNN result valid; releases the held frame.
- valid_out  output  1  one-cycle pulse: image_out holds a complete frame.
- image_out  output  DATA_WIDTH x [0:IMG_SIZE*IMG_SIZE-1]  unpacked frame array, raster order.
- busy  output  1  high whenever the state is not FILL.
- frame_err  output  1  one-cycle pulse on a framing error.
- frame_cnt  output  CNT_WIDTH  count of launched frames; wraps.

Behaviour:
- Reset (rst==0 at a posedge):
  - state=FILL, wr_idx=0, all buffer entries 0.
  - valid_out=0, frame_err=0, frame_cnt=0, busy=0.
  - pix_ready is forced 0 while rst==0.
- pix_ready = (state==FILL) && rst. Combinational from state; no dependence on pix_valid.
- Transfer occurs when pix_valid && pix_ready at a posedge. On transfer: buf[wr_idx] <= pix_data.
- FILL state, on a transfer:
  - wr_idx < last index, pix_last=0: wr_idx increments.
  - wr_idx < last index, pix_last=1 (early last): frame_err pulses next cycle, wr_idx<=0, frame discarded, state stays FILL.
  - wr_idx == last index, pix_last=0 (missing last): frame_err pulses, wr_idx<=0, frame discarded, state stays FILL.
  - wr_idx == last index, pix_last=1: state<=LAUNCH, wr_idx<=0.
  - Discarded pixels remain in the buffer but are never launched.
- LAUNCH: valid_out=1 for exactly this cycle, frame_cnt increments, state<=WAIT.
- WAIT: pix_ready=0. When cnn_done==1, state<=FILL.
- cnn_done is ignored in FILL and LAUNCH.
- Latency: valid_out is asserted 1 cycle after the accepting edge of the final pixel.
- image_out is driven continuously from the buffer. It is stable from the LAUNCH cycle until the cycle after cnn_done; the buffer is not written in LAUNCH or WAIT.
- Reset mid-frame or in WAIT: the full reset values above apply and the partial frame is lost.
- Back-to-back: next pixel accepted no earlier than the cycle after cnn_done is sampled.

Optional Feature:
- Macro: IMAGE_LOADER_DOUBLE_BUFFER_EN.
- When defined:
  - Two banks (ping-pong).
  - In WAIT, pix_ready=1 and incoming pixels fill the inactive bank.
  - If that bank completes before cnn_done, the state is PENDING with pix_ready=0.
  - On cnn_done in PENDING: banks swap, state<=LAUNCH (valid_out on the following cycle).
  - On cnn_done in WAIT with a partial fill: active bank is released, the fill continues, state<=FILL targeting the same bank.
  - image_out always shows the active bank.
  - Framing errors in the inactive bank pulse frame_err and never disturb the active bank.
- When undefined: single bank, no PENDING state, behaviour exactly as above.

Decomposition:
- Package cnn_pkg holds:
  - IMG_PIXELS = IMG_SIZE*IMG_SIZE.
  - PIX_W.
  - Index width $clog2(IMG_PIXELS).
  - Typedef loader_state_t {FILL, LAUNCH, WAIT, PENDING}.
  - Typedef pixel_t.
- One sub-module, frame_bank: write-indexed register array with parallel read. Instantiated once, or twice under the macro.

Test Plan:
- Reset then stream pixels 0..783 with pix_data=idx[7:0] and pix_last on 783 -> valid_out pulse 1 cycle after the last accept; image_out[i]=i%256; frame_cnt=1; busy=1.
- In WAIT, hold pix_valid=1 for 50 cycles then pulse cnn_done -> pix_ready=0 and image_out unchanged throughout; pix_ready=1 the cycle after cnn_done; busy=0.
- pix_last asserted on pixel 100 -> frame_err pulse, no valid_out; a following clean 784-pixel frame launches normally with frame_cnt=1.
- 784 pixels with no pix_last -> frame_err pulse, no valid_out, wr_idx back at 0.
- Deassert rst at pixel 400 -> pix_ready=0 during reset; all image_out=0, frame_cnt=0; a fresh frame then completes correctly.
- Random pix_valid gaps (30% idle) over 3 frames -> data matches the reference model; frame_cnt=3. With IMAGE_LOADER_DOUBLE_BUFFER_EN: second frame is accepted during WAIT and launches 1 cycle after cnn_done.
